// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged synchronous FIFO family.
//   SHOWAHEAD_REG / SHOWAHEAD_FWFT : read-mode encodings for the SHOWAHEAD parameter
//   DEF_ABITS / DEF_DBITS          : default address and data widths
//   count_width()                  : occupancy width, wide enough to hold 0..2**abits
package fifo_pkg;

    localparam int unsigned SHOWAHEAD_REG  = 0;
    localparam int unsigned SHOWAHEAD_FWFT = 1;

    localparam int unsigned DEF_ABITS = 4;
    localparam int unsigned DEF_DBITS = 8;

    function automatic int unsigned count_width(input int unsigned abits);
        return abits + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_flagged_if.sv
// Handshake/status bundle of fifo_sync_flagged.
//   master : producer/consumer side (drives wr, din, rd, thresholds, clr_err)
//   slave  : FIFO side (drives dout, dout_valid, count and all flags)
interface fifo_sync_flagged_if
    import fifo_pkg::*;
#(
    parameter int unsigned ABITS = DEF_ABITS,
    parameter int unsigned DBITS = DEF_DBITS
);
    logic             wr;
    logic [DBITS-1:0] din;
    logic             rd;
    logic [DBITS-1:0] dout;
    logic             dout_valid;
    logic             empty;
    logic             full;
    logic [ABITS:0]   ae_thresh;
    logic [ABITS:0]   af_thresh;
    logic             almost_empty;
    logic             almost_full;
    logic [ABITS:0]   count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output wr, din, rd, ae_thresh, af_thresh, clr_err,
        input  dout, dout_valid, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );

    modport slave (
        input  wr, din, rd, ae_thresh, af_thresh, clr_err,
        output dout, dout_valid, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port RAM, 2**ABITS x DBITS, synchronous write.
//   clock, reset_n      : clock, synchronous active-low reset (registered read data only)
//   we, waddr, wdata    : write port
//   re, raddr, rdata    : read port; REG_READ=1 registers rdata on re, REG_READ=0 is
//                         a combinational read of mem[raddr]
// A registered read and a write to the same address on one edge return the old word.
module fifo_ram #(
    parameter int unsigned ABITS    = 4,
    parameter int unsigned DBITS    = 8,
    parameter bit          REG_READ = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [DBITS-1:0] wdata,
    input  logic             re,
    input  logic [ABITS-1:0] raddr,
    output logic [DBITS-1:0] rdata
);
    logic [DBITS-1:0] mem [2**ABITS];

    // Contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    if (REG_READ) begin : g_reg_read
        logic [DBITS-1:0] rdata_q;

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                rdata_q <= '0;
            end else if (re) begin
                rdata_q <= mem[raddr];
            end
        end

        assign rdata = rdata_q;
    end else begin : g_async_read
        logic [1:0] unused_ctrl;

        assign rdata       = mem[raddr];
        assign unused_ctrl = {reset_n, re};
    end
endmodule

// File: rtl/fifo_sync_flagged.sv
// Single-clock FIFO with exact occupancy, programmable almost-empty/almost-full flags,
// sticky overflow/underflow flags and a selectable read mode.
//   clock    : rising-edge clock
//   reset_n  : synchronous active-low reset
//   bus      : slave side of fifo_sync_flagged_if (requests, data, thresholds, status)
// SHOWAHEAD=SHOWAHEAD_REG gives a one-cycle registered read with a dout_valid pulse;
// SHOWAHEAD=SHOWAHEAD_FWFT exposes the head word on dout while the FIFO is non-empty.
module fifo_sync_flagged
    import fifo_pkg::*;
#(
    parameter int unsigned ABITS     = DEF_ABITS,
    parameter int unsigned DBITS     = DEF_DBITS,
    parameter int unsigned SHOWAHEAD = SHOWAHEAD_REG
) (
    input logic                clock,
    input logic                reset_n,
    fifo_sync_flagged_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ABITS;
    localparam int unsigned CBITS = count_width(ABITS);

    logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CBITS-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ae_q, ae_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rd_acc, wr_acc;
    logic [DBITS-1:0] ram_rdata;

    // Requests seen during reset are dropped. A full FIFO takes a write only when the
    // same-cycle read frees a slot; a write never makes a read of an empty FIFO legal.
    assign rd_acc = reset_n & bus.rd & ~empty_q;
    assign wr_acc = reset_n & bus.wr & (~full_q | rd_acc);

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + ABITS'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ABITS'(1) : rd_ptr_q;
        count_d  = count_q + CBITS'(wr_acc) - CBITS'(rd_acc);

        // Flags come from count_d so they always line up with the registered count.
        empty_d  = (count_d == '0);
        full_d   = (count_d == CBITS'(DEPTH));
        ae_d     = (count_d <= bus.ae_thresh);
        af_d     = (count_d >= bus.af_thresh);

        // Clear wins over a same-cycle error event.
        ovf_d    = bus.clr_err ? 1'b0 : (ovf_q | (bus.wr & ~wr_acc));
        unf_d    = bus.clr_err ? 1'b0 : (unf_q | (bus.rd & ~rd_acc));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_ram #(
        .ABITS    (ABITS),
        .DBITS    (DBITS),
        .REG_READ (SHOWAHEAD != SHOWAHEAD_FWFT)
    ) u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (wr_acc),
        .waddr   (wr_ptr_q),
        .wdata   (bus.din),
        .re      (rd_acc),
        .raddr   (rd_ptr_q),
        .rdata   (ram_rdata)
    );

    if (SHOWAHEAD == SHOWAHEAD_FWFT) begin : g_fwft
        assign bus.dout_valid = ~empty_q;
    end else begin : g_reg
        logic dv_q;

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                dv_q <= 1'b0;
            end else begin
                dv_q <= rd_acc;
            end
        end

        assign bus.dout_valid = dv_q;
    end

    assign bus.dout         = ram_rdata;
    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_sync_flagged.sv
// Drives a registered-read and a show-ahead instance with identical stimulus and checks
// both against a queue-based reference model after every clock edge.
module tb_fifo_sync_flagged;
    localparam int unsigned ABITS = 2;
    localparam int unsigned DBITS = 8;
    localparam int unsigned DEPTH = 4;

    logic             clock;
    logic             reset_n;
    logic             wr;
    logic             rd;
    logic             clr_err;
    logic [DBITS-1:0] din;
    logic [ABITS:0]   ae_thresh;
    logic [ABITS:0]   af_thresh;

    int n_tests = 0;
    int n_fail  = 0;
    int step_no = 0;

    // Reference model state
    logic [DBITS-1:0] q[$];
    logic [DBITS-1:0] m_dout;
    logic             m_dv;
    logic             m_ovf;
    logic             m_unf;
    logic             m_ae;
    logic             m_af;

    fifo_sync_flagged_if #(.ABITS(ABITS), .DBITS(DBITS)) bus_reg ();
    fifo_sync_flagged_if #(.ABITS(ABITS), .DBITS(DBITS)) bus_fa ();

    assign bus_reg.wr        = wr;
    assign bus_reg.rd        = rd;
    assign bus_reg.din       = din;
    assign bus_reg.clr_err   = clr_err;
    assign bus_reg.ae_thresh = ae_thresh;
    assign bus_reg.af_thresh = af_thresh;
    assign bus_fa.wr         = wr;
    assign bus_fa.rd         = rd;
    assign bus_fa.din        = din;
    assign bus_fa.clr_err    = clr_err;
    assign bus_fa.ae_thresh  = ae_thresh;
    assign bus_fa.af_thresh  = af_thresh;

    fifo_sync_flagged #(.ABITS(ABITS), .DBITS(DBITS), .SHOWAHEAD(0)) u_reg (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_reg)
    );

    fifo_sync_flagged #(.ABITS(ABITS), .DBITS(DBITS), .SHOWAHEAD(1)) u_fa (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_fa)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance model at the edge, compare 1 time unit later.
    task automatic step(input logic r_n, input logic w, input logic [DBITS-1:0] d,
                        input logic r, input logic c,
                        input logic [ABITS:0] ae, input logic [ABITS:0] af);
        bit ra;
        bit wa;
        reset_n   = r_n;
        wr        = w;
        din       = d;
        rd        = r;
        clr_err   = c;
        ae_thresh = ae;
        af_thresh = af;
        @(posedge clock);
        step_no++;
        if (!r_n) begin
            q.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_ae   = 1'b1;
            m_af   = 1'b0;
        end else begin
            ra = r && (q.size() > 0);
            wa = w && ((q.size() < DEPTH) || ra);
            m_dv = ra;
            if (ra) m_dout = q.pop_front();
            if (wa) q.push_back(d);
            if (c) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                if (w && !wa) m_ovf = 1'b1;
                if (r && !ra) m_unf = 1'b1;
            end
            m_ae = (q.size() <= int'(ae));
            m_af = (q.size() >= int'(af));
        end
        #1;
        check("reg.count", 32'(bus_reg.count), 32'(q.size()));
        check("reg.empty", 32'(bus_reg.empty), 32'(q.size() == 0));
        check("reg.full", 32'(bus_reg.full), 32'(q.size() == DEPTH));
        check("reg.almost_empty", 32'(bus_reg.almost_empty), 32'(m_ae));
        check("reg.almost_full", 32'(bus_reg.almost_full), 32'(m_af));
        check("reg.overflow", 32'(bus_reg.overflow), 32'(m_ovf));
        check("reg.underflow", 32'(bus_reg.underflow), 32'(m_unf));
        check("reg.dout_valid", 32'(bus_reg.dout_valid), 32'(m_dv));
        check("reg.dout", 32'(bus_reg.dout), 32'(m_dout));
        check("fa.count", 32'(bus_fa.count), 32'(q.size()));
        check("fa.empty", 32'(bus_fa.empty), 32'(q.size() == 0));
        check("fa.full", 32'(bus_fa.full), 32'(q.size() == DEPTH));
        check("fa.almost_empty", 32'(bus_fa.almost_empty), 32'(m_ae));
        check("fa.almost_full", 32'(bus_fa.almost_full), 32'(m_af));
        check("fa.overflow", 32'(bus_fa.overflow), 32'(m_ovf));
        check("fa.underflow", 32'(bus_fa.underflow), 32'(m_unf));
        check("fa.dout_valid", 32'(bus_fa.dout_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("fa.dout", 32'(bus_fa.dout), 32'(q[0]));
    endtask

    initial begin
        logic             rw;
        logic             rr;
        logic             rc;
        logic [ABITS:0]   rae;
        logic [ABITS:0]   raf;

        // Reset with requests asserted: they must be ignored.
        step(0, 1, 8'hEE, 1, 0, 1, 3);
        step(0, 1, 8'hEF, 0, 0, 1, 3);

        // Fill 0x11..0x44: almost_full at 3, full at 4.
        step(1, 1, 8'h11, 0, 0, 1, 3);
        step(1, 1, 8'h22, 0, 0, 1, 3);
        step(1, 1, 8'h33, 0, 0, 1, 3);
        step(1, 1, 8'h44, 0, 0, 1, 3);
        // Write while full: overflow, count stays 4.
        step(1, 1, 8'h55, 0, 0, 1, 3);
        // Clear with a same-cycle overflow event: clear wins.
        step(1, 1, 8'h56, 0, 1, 1, 3);
        // Read+write when full: old head out, new word appended.
        step(1, 1, 8'h66, 1, 0, 1, 3);
        // Drain.
        step(1, 0, 8'h00, 1, 0, 1, 3);
        step(1, 0, 8'h00, 1, 0, 1, 3);
        step(1, 0, 8'h00, 1, 0, 1, 3);
        step(1, 0, 8'h00, 1, 0, 1, 3);
        // Read while empty: underflow, dout held.
        step(1, 0, 8'h00, 1, 0, 1, 3);
        step(1, 0, 8'h00, 1, 1, 1, 3);
        // Read+write when empty: write lands, read rejected.
        step(1, 1, 8'h77, 1, 0, 1, 3);
        step(1, 0, 8'h00, 1, 1, 1, 3);
        // Show-ahead visibility: 0xA5 on dout with no rd, then popped.
        step(1, 1, 8'hA5, 0, 0, 1, 3);
        step(1, 0, 8'h00, 0, 0, 1, 3);
        step(1, 0, 8'h00, 1, 0, 1, 3);
        // Degenerate thresholds.
        step(1, 0, 8'h00, 0, 0, 4, 0);
        step(1, 1, 8'h12, 0, 0, 7, 0);
        step(1, 1, 8'h34, 0, 0, 0, 5);
        step(1, 0, 8'h00, 1, 0, 2, 2);
        step(1, 0, 8'h00, 1, 0, 0, 1);

        // Random stream with wrap-around and threshold changes.
        rae = 1;
        raf = 3;
        for (int i = 0; i < 400; i++) begin
            rw = ($urandom_range(0, 99) < 55);
            rr = ($urandom_range(0, 99) < 50);
            rc = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) rae = ABITS'(0) + $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) raf = ABITS'(0) + $urandom_range(0, 7);
            step(1, rw, 8'($urandom), rr, rc, rae, raf);
        end

        // Reset mid-stream with count = 3, then reuse from address 0.
        step(0, 0, 8'h00, 0, 0, 1, 3);
        step(1, 1, 8'hC1, 0, 0, 1, 3);
        step(1, 1, 8'hC2, 0, 0, 1, 3);
        step(1, 1, 8'hC3, 1, 0, 1, 3);
        step(1, 1, 8'hC4, 0, 0, 1, 3);
        step(1, 1, 8'hC5, 1, 1, 1, 3);
        step(0, 1, 8'hC6, 1, 0, 1, 3);
        step(1, 1, 8'hD1, 0, 0, 1, 3);
        step(1, 1, 8'hD2, 0, 0, 1, 3);
        step(1, 1, 8'hD3, 0, 0, 1, 3);
        step(1, 0, 8'h00, 1, 0, 1, 3);
        step(1, 0, 8'h00, 1, 0, 1, 3);
        step(1, 0, 8'h00, 1, 0, 1, 3);
        step(1, 0, 8'h00, 1, 0, 1, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
